parking_slot_detector: RTL and testbench

PARKING_SLOT_DETECTOR -- requirements
Module: parking_slot_detector

---
 rtl/parking_slot_detector.sv | 127 ++++++++++++
 tb/tb_parking_slot_detector.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/parking_slot_detector.sv
// Purpose : four-slot parking occupancy detector; debounces each raw sensor and
//           emits one-cycle entry/exit pulses plus free-slot count and full flag.
// Latency : DEBOUNCE_CYCLES+3 edges from first sampled sensor change to pulse.
// Backpressure : none; pulses are fire-and-forget, the consumer must sample each cycle.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset_n      synchronous active-low reset
//   sensor_raw   raw per-slot sensors (1 = car present), asynchronous, may bounce
//   slot_enable  per-slot enable (0 = out of service, slot forced EMPTY)
//   car_entry    one-cycle pulse per slot on accepted arrival
//   car_exit     one-cycle pulse per slot on accepted departure
//   occupied     per-slot debounced occupancy
//   free_count   number of unoccupied slots (0..4)
//   full         high when no slot is free
module parking_slot_detector #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sensor_raw,
  input  logic [3:0] slot_enable,
  output logic [3:0] car_entry,
  output logic [3:0] car_exit,
  output logic [3:0] occupied,
  output logic [2:0] free_count,
  output logic       full
);

  typedef enum logic [1:0] {
    EMPTY       = 2'd0,
    ARRIVE_WAIT = 2'd1,
    OCCUPIED    = 2'd2,
    LEAVE_WAIT  = 2'd3
  } slot_state_t;

  // Terminal count: the state changes on the edge that sees the counter here,
  // so the counter itself never passes this value and cannot wrap.
  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  sync_meta;
  logic [3:0]  sync;
  slot_state_t state [4];
  logic [15:0] cnt   [4];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
      car_entry <= '0;
      car_exit  <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= EMPTY;
        cnt[i]   <= '0;
      end
    end else begin
      sync_meta <= sensor_raw;
      sync      <= sync_meta;
      car_entry <= '0;
      car_exit  <= '0;
      for (int i = 0; i < 4; i++) begin
        if (!slot_enable[i]) begin
          // Taking a slot out of service counts as a departure only if a car
          // had already been accepted there.
          state[i] <= EMPTY;
          cnt[i]   <= '0;
          if (state[i] == OCCUPIED || state[i] == LEAVE_WAIT)
            car_exit[i] <= 1'b1;
        end else begin
          unique case (state[i])
            EMPTY: begin
              if (sync[i]) begin
                state[i] <= ARRIVE_WAIT;
                cnt[i]   <= '0;
              end
            end
            ARRIVE_WAIT: begin
              if (!sync[i]) begin
                state[i] <= EMPTY;
              end else if (cnt[i] == LAST) begin
                state[i]     <= OCCUPIED;
                car_entry[i] <= 1'b1;
              end else if (cnt[i] < LAST) begin
                cnt[i] <= cnt[i] + 16'd1;
              end
            end
            OCCUPIED: begin
              if (!sync[i]) begin
                state[i] <= LEAVE_WAIT;
                cnt[i]   <= '0;
              end
            end
            LEAVE_WAIT: begin
              if (sync[i]) begin
                state[i] <= OCCUPIED;
              end else if (cnt[i] == LAST) begin
                state[i]    <= EMPTY;
                car_exit[i] <= 1'b1;
              end else if (cnt[i] < LAST) begin
                cnt[i] <= cnt[i] + 16'd1;
              end
            end
            default: begin
              state[i] <= EMPTY;
              cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Occupancy is a pure decode of the state registers; LEAVE_WAIT still counts
  // as occupied until the departure is accepted.
  logic [2:0] occ_sum;

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < 4; i++) begin
      occupied[i] = (state[i] == OCCUPIED) || (state[i] == LEAVE_WAIT);
      occ_sum     = occ_sum + {2'b00, occupied[i]};
    end
    free_count = 3'd4 - occ_sum;
    full       = (free_count == 3'd0);
  end

endmodule

// File: tb/tb_parking_slot_detector.sv
// Purpose : directed, table-driven check of parking_slot_detector with DEBOUNCE_CYCLES=4.
// Latency : each vector is applied after an edge and checked 1 time unit after the next edge.
// Backpressure : not applicable.
module tb_parking_slot_detector;

  logic       clk;
  logic       reset_n;
  logic [3:0] sensor_raw;
  logic [3:0] slot_enable;
  logic [3:0] car_entry;
  logic [3:0] car_exit;
  logic [3:0] occupied;
  logic [2:0] free_count;
  logic       full;

  parking_slot_detector #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor_raw  (sensor_raw),
    .slot_enable (slot_enable),
    .car_entry   (car_entry),
    .car_exit    (car_exit),
    .occupied    (occupied),
    .free_count  (free_count),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] sens;
    logic [3:0] en;
    int         reps;
    logic [3:0] entry;
    logic [3:0] ex;
    logic [3:0] occ;
    logic [2:0] free;
    logic       fl;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst_n, input logic [3:0] sens, input logic [3:0] en,
                     input int reps, input logic [3:0] entry, input logic [3:0] ex,
                     input logic [3:0] occ, input logic [2:0] free, input logic fl);
    vec_t v;
    v.rst_n = rst_n; v.sens = sens; v.en = en; v.reps = reps;
    v.entry = entry; v.ex = ex; v.occ = occ; v.free = free; v.fl = fl;
    tbl.push_back(v);
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Apply one input vector across one clock edge and check every output.
  task automatic step(input string tag, input logic rst_n, input logic [3:0] sens,
                      input logic [3:0] en, input logic [3:0] entry, input logic [3:0] ex,
                      input logic [3:0] occ, input logic [2:0] free, input logic fl);
    reset_n     = rst_n;
    sensor_raw  = sens;
    slot_enable = en;
    @(posedge clk);
    #1;
    chk4({tag, " car_entry"}, car_entry, entry);
    chk4({tag, " car_exit"}, car_exit, ex);
    chk4({tag, " occupied"}, occupied, occ);
    chk4({tag, " free_count"}, {1'b0, free_count}, {1'b0, free});
    chk4({tag, " full"}, {3'b000, full}, {3'b000, fl});
  endtask

  initial begin
    reset_n     = 1'b0;
    sensor_raw  = 4'b0000;
    slot_enable = 4'b1111;

    // rst, sens, en, reps, entry, exit, occ, free, full
    // reset state
    add(0, 4'b0000, 4'b1111, 2, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
    add(1, 4'b0000, 4'b1111, 2, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
    // scenario 1: slot 0 arrival, pulse after 7 edges
    add(1, 4'b0001, 4'b1111, 6, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
    add(1, 4'b0001, 4'b1111, 1, 4'b0001, 4'b0000, 4'b0001, 3'd3, 0);
    add(1, 4'b0001, 4'b1111, 3, 4'b0000, 4'b0000, 4'b0001, 3'd3, 0);
    // scenario 2: slot 1 glitch of 3 cycles is rejected
    add(1, 4'b0011, 4'b1111, 3, 4'b0000, 4'b0000, 4'b0001, 3'd3, 0);
    add(1, 4'b0001, 4'b1111, 6, 4'b0000, 4'b0000, 4'b0001, 3'd3, 0);
    // scenario 3: short dropout on slot 0 ignored, long one accepted
    add(1, 4'b0000, 4'b1111, 2, 4'b0000, 4'b0000, 4'b0001, 3'd3, 0);
    add(1, 4'b0001, 4'b1111, 6, 4'b0000, 4'b0000, 4'b0001, 3'd3, 0);
    add(1, 4'b0000, 4'b1111, 6, 4'b0000, 4'b0000, 4'b0001, 3'd3, 0);
    add(1, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0001, 4'b0000, 3'd4, 0);
    add(1, 4'b0000, 4'b1111, 2, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
    // scenario 4: all four arrive together
    add(1, 4'b1111, 4'b1111, 6, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
    add(1, 4'b1111, 4'b1111, 1, 4'b1111, 4'b0000, 4'b1111, 3'd0, 1);
    add(1, 4'b1111, 4'b1111, 2, 4'b0000, 4'b0000, 4'b1111, 3'd0, 1);
    // scenario 5: slot 2 taken out of service
    add(1, 4'b1111, 4'b1011, 1, 4'b0000, 4'b0100, 4'b1011, 3'd1, 0);
    add(1, 4'b1111, 4'b1011, 4, 4'b0000, 4'b0000, 4'b1011, 3'd1, 0);
    // slot 1 leaves so only slots 0 and 3 remain
    add(1, 4'b1001, 4'b1011, 6, 4'b0000, 4'b0000, 4'b1011, 3'd1, 0);
    add(1, 4'b1001, 4'b1011, 1, 4'b0000, 4'b0010, 4'b1001, 3'd2, 0);
    add(1, 4'b1001, 4'b1011, 1, 4'b0000, 4'b0000, 4'b1001, 3'd2, 0);
    // scenario 6: one-cycle reset discards occupancy silently, then re-entry
    add(0, 4'b1001, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
    add(1, 4'b1001, 4'b1111, 6, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
    add(1, 4'b1001, 4'b1111, 1, 4'b1001, 4'b0000, 4'b1001, 3'd2, 0);
    add(1, 4'b1001, 4'b1111, 2, 4'b0000, 4'b0000, 4'b1001, 3'd2, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        step($sformatf("row%0d.%0d", r, k), tbl[r].rst_n, tbl[r].sens, tbl[r].en,
             tbl[r].entry, tbl[r].ex, tbl[r].occ, tbl[r].free, tbl[r].fl);
      end
    end

    // Disable during ARRIVE_WAIT: slot 2 mid-debounce, no pulse, then fresh debounce.
    for (int k = 0; k < 4; k++)
      step($sformatf("aw_pre%0d", k), 1, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 4'b1001, 3'd2, 0);
    step("aw_disable", 1, 4'b1101, 4'b1011, 4'b0000, 4'b0000, 4'b1001, 3'd2, 0);
    for (int k = 0; k < 4; k++)
      step($sformatf("aw_redo%0d", k), 1, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 4'b1001, 3'd2, 0);
    step("aw_entry", 1, 4'b1101, 4'b1111, 4'b0100, 4'b0000, 4'b1101, 3'd1, 0);

    // Disable during LEAVE_WAIT: slot 3 departing, disable yields an immediate exit pulse.
    for (int k = 0; k < 3; k++)
      step($sformatf("lw_pre%0d", k), 1, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 4'b1101, 3'd1, 0);
    step("lw_disable", 1, 4'b0101, 4'b0111, 4'b0000, 4'b1000, 4'b0101, 3'd2, 0);
    for (int k = 0; k < 3; k++)
      step($sformatf("lw_post%0d", k), 1, 4'b0101, 4'b0111, 4'b0000, 4'b0000, 4'b0101, 3'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
